// File: rtl/tia_playfield_pkg.sv
// Shared definitions for the TIA playfield serializer slice.
// Holds the default geometry, the FSM state encoding and a small sizing
// helper used by the serializer and its bit counter.
package tia_playfield_pkg;

    // Default geometry: 20 playfield bits per half-line, 4 colour clocks each.
    localparam int PF_WIDTH         = 20;
    localparam int PF_CELLS_PER_BIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } pf_state_e;

    // Width of the within-bit cell counter; never narrower than one bit so the
    // CELLS_PER_BIT == 1 case still has a legal (constant-zero) register.
    function automatic int sub_bits(input int cells_per_bit);
        if (cells_per_bit > 1) begin
            return $clog2(cells_per_bit);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/tia_playfield_if.sv
// Playfield serializer bus.
// master: register-write decoder / line timing side (drives en, start,
//         reflect, pf_wr, pf_data; observes pf_out, busy, half).
// slave : the serializer itself.
interface tia_playfield_if
    import tia_playfield_pkg::*;
#(
    parameter int WIDTH = PF_WIDTH
) ();

    logic             en;
    logic             start;
    logic             reflect;
    logic             pf_wr;
    logic [WIDTH-1:0] pf_data;
    logic             pf_out;
    logic             busy;
    logic             half;

    modport master (
        output en, start, reflect, pf_wr, pf_data,
        input  pf_out, busy, half
    );

    modport slave (
        input  en, start, reflect, pf_wr, pf_data,
        output pf_out, busy, half
    );

endinterface

// File: rtl/tia_playfield_bit_counter.sv
// Sub-cell / bit-index counter pair for the playfield serializer.
// Ports:
//   clk, rsyn     clock and synchronous active-high reset
//   load          load idx from load_idx, clear sub, take dir from load_dir
//   load_idx      starting bit index
//   load_dir      0 = ascending, 1 = descending
//   step          one colour-clock step (ignored when load is high)
//   idx           current bit index
//   term          last cell of the last bit in the current direction
module tia_playfield_bit_counter
    import tia_playfield_pkg::*;
#(
    parameter  int WIDTH         = PF_WIDTH,
    parameter  int CELLS_PER_BIT = PF_CELLS_PER_BIT,
    localparam int IDX_W         = $clog2(WIDTH),
    localparam int SUB_W         = sub_bits(CELLS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rsyn,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             load_dir,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic             term
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELLS_PER_BIT - 1);
    localparam logic [SUB_W-1:0] SUB_ZERO = {SUB_W{1'b0}};

    logic [IDX_W-1:0] idx_r;
    logic [SUB_W-1:0] sub_r;
    logic             dir_r;
    logic             bit_done_s;
    logic             end_idx_s;

    assign bit_done_s = (sub_r == SUB_LAST);
    assign end_idx_s  = dir_r ? (idx_r == IDX_ZERO) : (idx_r == IDX_LAST);
    assign term       = bit_done_s && end_idx_s;
    assign idx        = idx_r;

    // Counter state: load wins over step; idx holds at its end value.
    always_ff @(posedge clk) begin
        if (rsyn) begin
            idx_r <= IDX_ZERO;
            sub_r <= SUB_ZERO;
            dir_r <= 1'b0;
        end else if (load) begin
            idx_r <= load_idx;
            sub_r <= SUB_ZERO;
            dir_r <= load_dir;
        end else if (step) begin
            if (bit_done_s) begin
                sub_r <= SUB_ZERO;
                if (!end_idx_s) begin
                    idx_r <= dir_r ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));
                end
            end else begin
                sub_r <= sub_r + SUB_W'(1);
            end
        end
    end

endmodule

// File: rtl/tia_playfield_serializer.sv
// Double-buffered playfield serializer.
// Emits a WIDTH-bit playfield word one bit per CELLS_PER_BIT colour-clock
// enables over the left half, then again over the right half, optionally
// mirrored. shadow takes register writes at any time; active is the copy
// being displayed and is reloaded only at line start and at the half change.
// Ports:
//   clk    system clock
//   rsyn   synchronous active-high reset, overrides every other input
//   pf     tia_playfield_if.slave: en, start, reflect, pf_wr, pf_data in;
//          pf_out (registered pixel), busy, half out
module tia_playfield_serializer
    import tia_playfield_pkg::*;
#(
    parameter int WIDTH         = PF_WIDTH,
    parameter int CELLS_PER_BIT = PF_CELLS_PER_BIT
) (
    input  logic            clk,
    input  logic            rsyn,
    tia_playfield_if.slave  pf
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    pf_state_e        state_r;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] active_r;
    logic             pf_out_r;

    logic [WIDTH-1:0] reload_word_s;
    logic             busy_s;
    logic             step_s;
    logic             load_s;
    logic [IDX_W-1:0] load_idx_s;
    logic             load_dir_s;
    logic [IDX_W-1:0] idx_s;
    logic             term_s;

    // A write landing on a reload cycle goes straight into active.
    assign reload_word_s = pf.pf_wr ? pf.pf_data : shadow_r;
    assign busy_s        = (state_r == LEFT) || (state_r == RIGHT);

    // Counter control: start restarts the line (its en is not a pixel step);
    // the final LEFT step reloads for the right half.
    always_comb begin
        step_s     = 1'b0;
        load_s     = 1'b0;
        load_idx_s = IDX_ZERO;
        load_dir_s = 1'b0;
        if (pf.start) begin
            load_s = 1'b1;
        end else begin
            step_s = pf.en && busy_s;
            if ((state_r == LEFT) && step_s && term_s) begin
                load_s     = 1'b1;
                load_idx_s = pf.reflect ? IDX_LAST : IDX_ZERO;
                load_dir_s = pf.reflect;
            end else begin
                load_s = 1'b0;
            end
        end
    end

    tia_playfield_bit_counter #(
        .WIDTH         (WIDTH),
        .CELLS_PER_BIT (CELLS_PER_BIT)
    ) u_bit_counter (
        .clk      (clk),
        .rsyn     (rsyn),
        .load     (load_s),
        .load_idx (load_idx_s),
        .load_dir (load_dir_s),
        .step     (step_s),
        .idx      (idx_s),
        .term     (term_s)
    );

    // Line FSM, playfield buffers and the registered pixel output.
    always_ff @(posedge clk) begin
        if (rsyn) begin
            state_r  <= IDLE;
            shadow_r <= {WIDTH{1'b0}};
            active_r <= {WIDTH{1'b0}};
            pf_out_r <= 1'b0;
        end else begin
            if (pf.pf_wr) begin
                shadow_r <= pf.pf_data;
            end
            case (state_r)
                IDLE: begin
                    pf_out_r <= 1'b0;
                    if (pf.start) begin
                        active_r <= reload_word_s;
                        state_r  <= LEFT;
                    end
                end
                LEFT, RIGHT: begin
                    if (pf.start) begin
                        // Restart; pf_out keeps its last pixel until the first step.
                        active_r <= reload_word_s;
                        state_r  <= LEFT;
                    end else if (pf.en) begin
                        pf_out_r <= active_r[idx_s];
                        if (term_s) begin
                            if (state_r == LEFT) begin
                                active_r <= reload_word_s;
                                state_r  <= RIGHT;
                            end else begin
                                state_r  <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    pf_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign pf.pf_out = pf_out_r;
    assign pf.busy   = busy_s;
    assign pf.half   = (state_r == RIGHT);

endmodule
